// File: rtl/writeback_merge.sv
// Merges NUM_SRC result streams into one register-file write port through per-source FIFOs
// drained by a round-robin arbiter; also exports a pending-write mask and the JAL flush path.
module writeback_merge #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 4,
  parameter int XLEN    = 32,
  localparam int GW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [NUM_SRC-1:0]      src_valid,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic [NUM_SRC*5-1:0]    src_rd,
  input  logic [NUM_SRC*XLEN-1:0] src_data,
  input  logic                    jalF,
  input  logic [31:0]             target,
  output logic                    jal_flush,
  output logic [31:0]             j_target,
  output logic [XLEN-1:0]         write_data,
  output logic [4:0]              reg_num,
  output logic                    wen,
  output logic [4:0]              regD_ex,
  output logic [XLEN-1:0]         regD_val_ex,
  output logic                    regwrite_ex,
  output logic [GW-1:0]           grant_src,
  output logic [31:0]             pending_mask
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [4:0]        fifo_rd   [NUM_SRC][DEPTH];
  logic [XLEN-1:0]   fifo_data [NUM_SRC][DEPTH];
  logic [DEPTH-1:0]  entry_vld [NUM_SRC];
  logic [PW-1:0]     wr_ptr    [NUM_SRC];
  logic [PW-1:0]     rd_ptr    [NUM_SRC];
  logic [CW-1:0]     count     [NUM_SRC];
  logic [GW-1:0]     last_grant;

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic               gnt_found;
  logic [GW-1:0]      gnt_idx;
  logic [4:0]         head_rd;
  logic [XLEN-1:0]    head_data;

  // Ready depends only on the registered count; x0 writes complete the handshake but are dropped.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (count[i] < CW'(DEPTH));
      push[i]      = src_valid[i] && src_ready[i] && (src_rd[5*i +: 5] != 5'd0);
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!gnt_found && (count[(int'(last_grant) + k) % NUM_SRC] != '0)) begin
        gnt_found = 1'b1;
        gnt_idx   = GW'((int'(last_grant) + k) % NUM_SRC);
      end
    end
  end

  always_comb begin
    head_rd   = 5'd0;
    head_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = gnt_found && (gnt_idx == GW'(i));
      if (pop[i]) begin
        head_rd   = fifo_rd[i][rd_ptr[i]];
        head_data = fifo_data[i][rd_ptr[i]];
      end
    end
  end

  // Control state: pointers, occupancy, per-entry valid bits and arbiter history.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i]    <= '0;
        rd_ptr[i]    <= '0;
        count[i]     <= '0;
        entry_vld[i] <= '0;
      end
      last_grant <= GW'(NUM_SRC - 1);
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pop[i]) begin
          rd_ptr[i]               <= rd_ptr[i] + 1'b1;
          entry_vld[i][rd_ptr[i]] <= 1'b0;
        end
        if (push[i]) begin
          wr_ptr[i]               <= wr_ptr[i] + 1'b1;
          entry_vld[i][wr_ptr[i]] <= 1'b1;
        end
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
      if (gnt_found) last_grant <= gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        fifo_rd[i][wr_ptr[i]]   <= src_rd[5*i +: 5];
        fifo_data[i][wr_ptr[i]] <= src_data[XLEN*i +: XLEN];
      end
    end
  end

  // An entry stays visible in the mask until the edge that writes it.
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (entry_vld[i][j]) pending_mask[fifo_rd[i][j]] = 1'b1;
      end
    end
    pending_mask[0] = 1'b0;
  end

  assign wen         = gnt_found;
  assign reg_num     = head_rd;
  assign write_data  = head_data;
  assign grant_src   = gnt_idx;
  assign regD_ex     = head_rd;
  assign regD_val_ex = head_data;
  assign regwrite_ex = gnt_found;
  assign jal_flush   = jalF;
  assign j_target    = target;

endmodule

// File: tb/tb_writeback_merge.sv
// Bench for writeback_merge: directed scenarios plus randomized traffic against a queue-based model.
module tb_writeback_merge;
  localparam int NS = 2;
  localparam int D  = 4;
  localparam int XL = 32;

  logic           clk = 1'b0;
  logic           n_rst;
  logic [NS-1:0]  src_valid, src_ready;
  logic [NS*5-1:0]  src_rd;
  logic [NS*XL-1:0] src_data;
  logic           jalF;
  logic [31:0]    target, j_target;
  logic           jal_flush;
  logic [XL-1:0]  write_data, regD_val_ex;
  logic [4:0]     reg_num, regD_ex;
  logic           wen, regwrite_ex;
  logic [0:0]     grant_src;
  logic [31:0]    pending_mask;

  int checks = 0;
  int errors = 0;

  logic [36:0] mq [NS][$];
  int m_last;

  writeback_merge #(.NUM_SRC(NS), .DEPTH(D), .XLEN(XL)) dut (
    .clk(clk), .n_rst(n_rst), .src_valid(src_valid), .src_ready(src_ready),
    .src_rd(src_rd), .src_data(src_data), .jalF(jalF), .target(target),
    .jal_flush(jal_flush), .j_target(j_target), .write_data(write_data),
    .reg_num(reg_num), .wen(wen), .regD_ex(regD_ex), .regD_val_ex(regD_val_ex),
    .regwrite_ex(regwrite_ex), .grant_src(grant_src), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  function automatic int m_grant();
    for (int k = 1; k <= NS; k++) begin
      if (mq[(m_last + k) % NS].size() > 0) return (m_last + k) % NS;
    end
    return -1;
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p = '0;
    logic [36:0] e;
    for (int s = 0; s < NS; s++)
      for (int j = 0; j < mq[s].size(); j++) begin
        e = mq[s][j];
        p[e[36:32]] = 1'b1;
      end
    p[0] = 1'b0;
    return p;
  endfunction

  function automatic logic [NS-1:0] m_ready();
    logic [NS-1:0] r;
    for (int s = 0; s < NS; s++) r[s] = (mq[s].size() < D);
    return r;
  endfunction

  task automatic set_idle();
    src_valid = '0; src_rd = '0; src_data = '0; jalF = 1'b0; target = '0;
  endtask

  task automatic clear_model();
    for (int s = 0; s < NS; s++) mq[s].delete();
    m_last = NS - 1;
  endtask

  // Advance model and DUT by one clock edge using the inputs currently applied.
  task automatic tick();
    logic [NS-1:0] rdy;
    int g;
    rdy = m_ready();
    g = m_grant();
    if (g >= 0) begin
      mq[g].delete(0);
      m_last = g;
    end
    for (int s = 0; s < NS; s++)
      if (src_valid[s] && rdy[s] && src_rd[5*s +: 5] != 5'd0)
        mq[s].push_back({src_rd[5*s +: 5], src_data[XL*s +: XL]});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    n_rst = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    n_rst = 1'b0;
    clear_model();
    #2;
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", wen); end
    checks++; if (reg_num !== 5'd0 || write_data !== '0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", reg_num, write_data); end
    checks++; if (grant_src !== 1'b0) begin errors++; $display("FAIL reset_grant got %h exp 0", grant_src); end
    checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", pending_mask); end
    checks++; if (src_ready !== 2'b11) begin errors++; $display("FAIL reset_ready got %b exp 11", src_ready); end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    src_valid = 2'b01; src_rd[4:0] = 5'd5; src_data[31:0] = 32'hDEADBEEF;
    #2;
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL single_no_comb_path got %b exp 0", wen); end
    tick();
    set_idle();
    #2;
    checks++; if ({wen, reg_num, write_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++;
      $display("FAIL single_write got %b/%0d/%h exp 1/5/deadbeef", wen, reg_num, write_data); end
    checks++; if ({regwrite_ex, regD_ex, regD_val_ex} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin errors++;
      $display("FAIL single_fwd got %b/%0d/%h exp 1/5/deadbeef", regwrite_ex, regD_ex, regD_val_ex); end
    checks++; if (grant_src !== 1'b0) begin errors++; $display("FAIL single_grant got %0d exp 0", grant_src); end
    checks++; if (pending_mask !== 32'h20) begin errors++; $display("FAIL single_pending got %h exp 20", pending_mask); end
    tick();
    #2;
    checks++; if (wen !== 1'b0 || pending_mask !== 32'h0) begin errors++;
      $display("FAIL single_after got %b/%h exp 0/0", wen, pending_mask); end
    tick();
  endtask

  task automatic test_round_robin();
    int src, ent;
    do_reset();
    for (int j = 0; j < 8; j++) begin
      set_idle();
      if (j < 3) begin
        src_valid = 2'b11;
        for (int s = 0; s < NS; s++) begin
          src_rd[5*s +: 5]    = 5'(1 + 8*s + j);
          src_data[XL*s +: XL] = 32'hA000_0000 + 32'(16*s + j);
        end
      end
      #2;
      if (j >= 1 && j <= 6) begin
        src = (j - 1) % 2; ent = (j - 1) / 2;
        checks++; if ({wen, grant_src, reg_num, write_data} !== {1'b1, 1'(src), 5'(1 + 8*src + ent), 32'hA000_0000 + 32'(16*src + ent)}) begin
          errors++; $display("FAIL rr_cycle%0d got %b/%0d/%0d/%h exp 1/%0d/%0d/%h", j, wen, grant_src, reg_num, write_data,
                             src, 1 + 8*src + ent, 32'hA000_0000 + 32'(16*src + ent)); end
      end else if (j == 7) begin
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL rr_drained got %b exp 0", wen); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int acc1 = 0, wr1 = 0, g;
    bit saw_full = 0;
    logic [36:0] h;
    do_reset();
    for (int c = 0; c < 24; c++) begin
      set_idle();
      if (c < 14) begin
        src_valid = 2'b11;
        src_rd[4:0] = 5'd2; src_data[31:0] = 32'h0000_0100 + 32'(c);
        src_rd[9:5] = 5'(9 + c % 4); src_data[63:32] = 32'h0000_1000 + 32'(c);
        if (m_ready() & 2'b10) acc1++;
      end
      #2;
      g = m_grant();
      if (!src_ready[1]) saw_full = 1;
      checks++; if (src_ready !== m_ready()) begin errors++; $display("FAIL bp_ready c%0d got %b exp %b", c, src_ready, m_ready()); end
      if (g >= 0) begin
        h = mq[g][0];
        checks++; if ({wen, grant_src, reg_num, write_data} !== {1'b1, 1'(g), h}) begin errors++;
          $display("FAIL bp_write c%0d got %b/%0d/%0d/%h exp 1/%0d/%0d/%h", c, wen, grant_src, reg_num, write_data, g, h[36:32], h[31:0]); end
        if (g == 1) wr1++;
      end else begin
        checks++; if (wen !== 1'b0) begin errors++; $display("FAIL bp_idle c%0d got %b exp 0", c, wen); end
      end
      tick();
    end
    checks++; if (!saw_full) begin errors++; $display("FAIL bp_full_seen got 0 exp 1"); end
    checks++; if (wr1 != acc1) begin errors++; $display("FAIL bp_count got %0d exp %0d", wr1, acc1); end
  endtask

  task automatic test_x0_drop();
    do_reset();
    src_valid = 2'b01; src_rd[4:0] = 5'd0; src_data[31:0] = 32'h1234;
    #2;
    checks++; if (src_ready[0] !== 1'b1) begin errors++; $display("FAIL x0_ready got %b exp 1", src_ready[0]); end
    tick();
    set_idle();
    #2;
    checks++; if ({wen, pending_mask, src_ready} !== {1'b0, 32'h0, 2'b11}) begin errors++;
      $display("FAIL x0_dropped got %b/%h/%b exp 0/0/11", wen, pending_mask, src_ready); end
    tick();
    #2;
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL x0_late got %b exp 0", wen); end
    tick();
  endtask

  task automatic test_jal();
    do_reset();
    src_valid = 2'b01; src_rd[4:0] = 5'd7; src_data[31:0] = 32'h77;
    tick();
    set_idle();
    jalF = 1'b1; target = 32'h80;
    #2;
    checks++; if ({jal_flush, j_target} !== {1'b1, 32'h80}) begin errors++;
      $display("FAIL jal_pass got %b/%h exp 1/80", jal_flush, j_target); end
    checks++; if ({wen, reg_num, write_data} !== {1'b1, 5'd7, 32'h77}) begin errors++;
      $display("FAIL jal_write got %b/%0d/%h exp 1/7/77", wen, reg_num, write_data); end
    tick();
    jalF = 1'b0;
    #2;
    checks++; if ({jal_flush, wen} !== 2'b00) begin errors++; $display("FAIL jal_after got %b/%b exp 0/0", jal_flush, wen); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_valid = 2'b11; src_rd = {5'd4, 5'd3};
    tick();
    src_rd = {5'd10, 5'd6};
    tick();
    set_idle();
    #2;
    checks++; if (pending_mask !== 32'h450) begin errors++; $display("FAIL midrst_queued got %h exp 450", pending_mask); end
    #1 n_rst = 1'b0;
    clear_model();
    #1;
    checks++; if ({wen, reg_num, pending_mask, src_ready} !== {1'b0, 5'd0, 32'h0, 2'b11}) begin errors++;
      $display("FAIL midrst_clear got %b/%0d/%h/%b exp 0/0/0/11", wen, reg_num, pending_mask, src_ready); end
    @(posedge clk);
    #1 n_rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      checks++; if (wen !== 1'b0) begin errors++; $display("FAIL midrst_nowrite c%0d got %b exp 0", c, wen); end
      tick();
    end
  endtask

  task automatic test_random();
    int g;
    logic [36:0] h;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < NS; s++) begin
        src_valid[s] = 1'($urandom_range(0, 1));
        src_rd[5*s +: 5] = 5'($urandom_range(0, 7));
        src_data[XL*s +: XL] = $urandom;
      end
      jalF = 1'($urandom_range(0, 1));
      target = $urandom;
      #2;
      g = m_grant();
      h = (g >= 0) ? mq[g][0] : 37'h0;
      checks++; if (src_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready c%0d got %b exp %b", c, src_ready, m_ready()); end
      checks++; if ({wen, grant_src, reg_num, write_data} !== {g >= 0, (g >= 0) ? 1'(g) : 1'b0, h}) begin errors++;
        $display("FAIL rnd_write c%0d got %b/%0d/%0d/%h exp %b/%0d/%0d/%h", c, wen, grant_src, reg_num, write_data, g >= 0, g, h[36:32], h[31:0]); end
      checks++; if ({regwrite_ex, regD_ex, regD_val_ex} !== {g >= 0, h}) begin errors++;
        $display("FAIL rnd_fwd c%0d got %b/%0d/%h exp %b/%0d/%h", c, regwrite_ex, regD_ex, regD_val_ex, g >= 0, h[36:32], h[31:0]); end
      checks++; if (pending_mask !== m_pending()) begin errors++; $display("FAIL rnd_pending c%0d got %h exp %h", c, pending_mask, m_pending()); end
      checks++; if ({jal_flush, j_target} !== {jalF, target}) begin errors++;
        $display("FAIL rnd_jal c%0d got %b/%h exp %b/%h", c, jal_flush, j_target, jalF, target); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_x0_drop();
    test_jal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
